// File: rtl/foc_deadtime_gate_if.sv
// PWM bundle between the FOC PWM generator and the dead-time gate stage:
// three single-ended phase requests in, six complementary gate drives out.
interface foc_deadtime_gate_if;
    logic iPWM_u;
    logic iPWM_v;
    logic iPWM_w;
    logic oPWM_uh;
    logic oPWM_ul;
    logic oPWM_vh;
    logic oPWM_vl;
    logic oPWM_wh;
    logic oPWM_wl;

    modport master (
        output iPWM_u, iPWM_v, iPWM_w,
        input  oPWM_uh, oPWM_ul, oPWM_vh, oPWM_vl, oPWM_wh, oPWM_wl
    );

    modport slave (
        input  iPWM_u, iPWM_v, iPWM_w,
        output oPWM_uh, oPWM_ul, oPWM_vh, oPWM_vl, oPWM_wh, oPWM_wl
    );
endinterface

// File: rtl/foc_deadtime_gate.sv
// Three-phase complementary gate generator with per-phase dead time, global
// enable and fault shutdown. Define PWM_FAULT_LATCH_EN for a sticky fault.
module foc_deadtime_gate #(
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned CNT_W       = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iFault,
    input  logic iFault_clr,
    output logic oFault,
    foc_deadtime_gate_if.slave pwm_if
);

    typedef enum logic [2:0] {
        S_OFF,
        S_DT_H,
        S_HI,
        S_DT_L,
        S_LO
    } state_t;

    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q [3];
    state_t           state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       armed_q, armed_d;
    logic [2:0]       h_q, h_d;
    logic [2:0]       l_q, l_d;
    logic             fault_q, fault_d;
    logic             fault_cond;
    logic             block;
    logic [2:0]       pwm;

`ifdef PWM_FAULT_LATCH_EN
    assign fault_cond = fault_q | iFault;
    assign fault_d    = iFault | (fault_q & ~iFault_clr);
`else
    logic fault_clr_unused;
    assign fault_cond       = fault_q;
    assign fault_d          = iFault;
    assign fault_clr_unused = iFault_clr;
`endif

    assign block = fault_cond | ~iEn;
    assign pwm   = {pwm_if.iPWM_w, pwm_if.iPWM_v, pwm_if.iPWM_u};

    // armed: the opposite gate conducted right before this dead time, so a
    // reverting input may hand straight back to it. A dead time started from
    // S_OFF is never armed; a revert there restarts a full opposite dead time.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            armed_d[p] = armed_q[p];
            h_d[p]     = 1'b0;
            l_d[p]     = 1'b0;
            if (block) begin
                state_d[p] = S_OFF;
                cnt_d[p]   = '0;
                armed_d[p] = 1'b0;
            end else begin
                unique case (state_q[p])
                    S_OFF: begin
                        state_d[p] = pwm[p] ? S_DT_H : S_DT_L;
                        cnt_d[p]   = DT_LOAD;
                        armed_d[p] = 1'b0;
                    end
                    S_DT_H: begin
                        if (!pwm[p]) begin
                            if (armed_q[p]) begin
                                state_d[p] = S_LO;
                                l_d[p]     = 1'b1;
                            end else begin
                                state_d[p] = S_DT_L;
                                cnt_d[p]   = DT_LOAD;
                            end
                        end else if (cnt_q[p] == '0) begin
                            state_d[p] = S_HI;
                            h_d[p]     = 1'b1;
                        end else begin
                            cnt_d[p] = cnt_q[p] - CNT_ONE;
                        end
                    end
                    S_DT_L: begin
                        if (pwm[p]) begin
                            if (armed_q[p]) begin
                                state_d[p] = S_HI;
                                h_d[p]     = 1'b1;
                            end else begin
                                state_d[p] = S_DT_H;
                                cnt_d[p]   = DT_LOAD;
                            end
                        end else if (cnt_q[p] == '0) begin
                            state_d[p] = S_LO;
                            l_d[p]     = 1'b1;
                        end else begin
                            cnt_d[p] = cnt_q[p] - CNT_ONE;
                        end
                    end
                    S_HI: begin
                        if (pwm[p]) begin
                            h_d[p] = 1'b1;
                        end else begin
                            state_d[p] = S_DT_L;
                            cnt_d[p]   = DT_LOAD;
                            armed_d[p] = 1'b1;
                        end
                    end
                    S_LO: begin
                        if (!pwm[p]) begin
                            l_d[p] = 1'b1;
                        end else begin
                            state_d[p] = S_DT_H;
                            cnt_d[p]   = DT_LOAD;
                            armed_d[p] = 1'b1;
                        end
                    end
                    default: begin
                        state_d[p] = S_OFF;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int unsigned p = 0; p < 3; p++) begin
                state_q[p] <= S_OFF;
                cnt_q[p]   <= '0;
            end
            armed_q <= '0;
            h_q     <= '0;
            l_q     <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            h_q     <= h_d;
            l_q     <= l_d;
            fault_q <= fault_d;
        end
    end

    assign oFault         = fault_q;
    assign pwm_if.oPWM_uh = h_q[0];
    assign pwm_if.oPWM_ul = l_q[0];
    assign pwm_if.oPWM_vh = h_q[1];
    assign pwm_if.oPWM_vl = l_q[1];
    assign pwm_if.oPWM_wh = h_q[2];
    assign pwm_if.oPWM_wl = l_q[2];

endmodule
